// File: rtl/uart_host_if.sv
// uart_host_if: CPU register front end for the UART controller with a local RX holding FIFO.
// Optional interrupt output enabled by defining UART_HOST_IRQ_EN.
module uart_host_if #(
    parameter int WORD_SIZE = 8,
    parameter int RX_DEPTH  = 4,
    parameter int BUS_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [1:0]           req_addr,
    input  logic [BUS_W-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [BUS_W-1:0]     resp_rdata,
    output logic [WORD_SIZE-1:0] ctl_data_in,
    output logic                 ctl_write_nic,
    output logic                 ctl_read_nic,
    input  logic [WORD_SIZE-1:0] ctl_data_out,
    input  logic                 ctl_read_nic_i,
    output logic                 irq
);
    localparam int AW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, PULL, CAPTURE} state_t;
    state_t state, state_nx;

    logic [WORD_SIZE-1:0] fifo [RX_DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [AW:0]          count;
    logic [15:0]          tx_count;
    logic [2:0]           stall;
    logic                 underrun, overrun, irq_en;
    logic                 push, pop, rd, wr, empty, full, rx_empty_rd, stalled;
    logic [BUS_W-1:0]     status, rdata;
    logic                 unused;

    assign rd          = req_valid & ~req_we;
    assign wr          = req_valid & req_we;
    assign empty       = count == '0;
    assign full        = count == (AW+1)'(RX_DEPTH);
    assign pop         = rd && req_addr == 2'd0 && !empty;
    assign rx_empty_rd = rd && req_addr == 2'd0 && empty;
    // A pending word the full FIFO cannot take; counted to detect a stuck controller.
    assign stalled     = state == IDLE && full && ctl_read_nic_i;
    assign status      = BUS_W'({8'(count), 3'b000, irq, overrun, underrun, full, ~empty});
    assign unused      = ^req_wdata;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb
        state_nx = state == IDLE ? ((ctl_read_nic_i && !full) ? PULL : IDLE) :
                   state == PULL ? CAPTURE : IDLE;

    always_comb begin
        ctl_read_nic = state == PULL;
        push         = state == CAPTURE;
    end

    always_comb
        rdata = !rd                ? '0 :
                req_addr == 2'd0   ? (empty ? '0 : BUS_W'(fifo[rd_ptr])) :
                req_addr == 2'd1   ? BUS_W'(tx_count) :
                req_addr == 2'd2   ? status : BUS_W'(irq_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            ctl_write_nic <= 1'b0;
            ctl_data_in   <= '0;
            tx_count      <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            underrun      <= 1'b0;
            overrun       <= 1'b0;
            stall         <= '0;
        end else begin
            resp_valid    <= req_valid;
            resp_rdata    <= rdata;
            ctl_write_nic <= wr && req_addr == 2'd1;
            if (wr && req_addr == 2'd1) begin
                ctl_data_in <= req_wdata[WORD_SIZE-1:0];
                tx_count    <= tx_count + 16'd1;
            end
            if (push) begin
                fifo[wr_ptr] <= ctl_data_out;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (rx_empty_rd)
                underrun <= 1'b1;
            else if (wr && req_addr == 2'd3 && req_wdata[1])
                underrun <= 1'b0;
            if (stalled && stall == 3'd7)
                overrun <= 1'b1;
            else if (wr && req_addr == 2'd3 && req_wdata[2])
                overrun <= 1'b0;
            stall <= !stalled ? 3'd0 : stall == 3'd7 ? 3'd7 : stall + 3'd1;
        end
    end

`ifdef UART_HOST_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr && req_addr == 2'd3)
                irq_en <= req_wdata[0];
            irq <= irq_en & (~empty | underrun | overrun);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif
endmodule
